// File: rtl/game_dumper.sv
// Streams a loaded NES cartridge back out in iNES file order: regenerated header, PRG, then CHR.
// Define GAMEDUMP_NES20_EN to emit the header in NES 2.0 form instead of plain iNES 1.0.
module game_dumper #(
  parameter logic [24:0] PRG_BASE = 25'h0000000,
  parameter logic [24:0] CHR_BASE = 25'h0200000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  prg_pages,
  input  logic [7:0]  chr_pages,
  input  logic [63:0] mapper_flags,
  output logic [24:0] mem_addr,
  output logic        mem_rd,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {S_IDLE, S_HEADER, S_REQ, S_WAIT, S_OUT, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  ctr_q, ctr_d;
  logic [7:0]  prgPages_q, prgPages_d, chrPages_q, chrPages_d;
  logic [7:0]  mapper_q, mapper_d;
  logic        mirror_q, mirror_d, fourScreen_q, fourScreen_d, battery_q, battery_d;
  logic [24:0] memAddr_q, memAddr_d, bytesLeft_q, bytesLeft_d;
  logic        memRd_q, memRd_d, outValid_q, outValid_d;
  logic [7:0]  outData_q, outData_d;
  logic        busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic        regionChr_q, regionChr_d;
  logic [7:0]  hdrByte;
  logic        unusedFlags;

`ifdef GAMEDUMP_NES20_EN
  // {prg_nvram, prgram, submapper} captured for the NES 2.0 extension bytes
  logic [11:0] ext_q, ext_d;

  always_ff @(posedge clk) begin
    if (reset) ext_q <= '0;
    else       ext_q <= ext_d;
  end

  always_comb begin
    ext_d = ext_q;
    if (state_q == S_IDLE && start)
      ext_d = {mapper_flags[34:31], mapper_flags[29:26], mapper_flags[20:17]};
  end
`endif

  assign unusedFlags = ^mapper_flags;

  always_comb begin
    hdrByte = 8'h00;
    case (ctr_q)
      4'd0: hdrByte = 8'h4E;
      4'd1: hdrByte = 8'h45;
      4'd2: hdrByte = 8'h53;
      4'd3: hdrByte = 8'h1A;
      4'd4: hdrByte = prgPages_q;
      4'd5: hdrByte = chrPages_q;
      4'd6: hdrByte = {mapper_q[3:0], fourScreen_q, 1'b0, battery_q, mirror_q};
`ifdef GAMEDUMP_NES20_EN
      4'd7:  hdrByte = {mapper_q[7:4], 4'b1000};
      4'd8:  hdrByte = {ext_q[3:0], 4'h0};
      4'd10: hdrByte = ext_q[11:4];
      4'd11: hdrByte = (chrPages_q == 8'd0) ? 8'h07 : 8'h00;
`else
      4'd7: hdrByte = {mapper_q[7:4], 4'h0};
`endif
      default: hdrByte = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ctr_q        <= '0;
      prgPages_q   <= '0;
      chrPages_q   <= '0;
      mapper_q     <= '0;
      mirror_q     <= 1'b0;
      fourScreen_q <= 1'b0;
      battery_q    <= 1'b0;
      memAddr_q    <= '0;
      bytesLeft_q  <= '0;
      memRd_q      <= 1'b0;
      outValid_q   <= 1'b0;
      outData_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      regionChr_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ctr_q        <= ctr_d;
      prgPages_q   <= prgPages_d;
      chrPages_q   <= chrPages_d;
      mapper_q     <= mapper_d;
      mirror_q     <= mirror_d;
      fourScreen_q <= fourScreen_d;
      battery_q    <= battery_d;
      memAddr_q    <= memAddr_d;
      bytesLeft_q  <= bytesLeft_d;
      memRd_q      <= memRd_d;
      outValid_q   <= outValid_d;
      outData_q    <= outData_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      regionChr_q  <= regionChr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ctr_d        = ctr_q;
    prgPages_d   = prgPages_q;
    chrPages_d   = chrPages_q;
    mapper_d     = mapper_q;
    mirror_d     = mirror_q;
    fourScreen_d = fourScreen_q;
    battery_d    = battery_q;
    memAddr_d    = memAddr_q;
    bytesLeft_d  = bytesLeft_q;
    memRd_d      = memRd_q;
    outValid_d   = outValid_q;
    outData_d    = outData_q;
    busy_d       = busy_q;
    done_d       = done_q;
    error_d      = error_q;
    regionChr_d  = regionChr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          prgPages_d   = prg_pages;
          chrPages_d   = chr_pages;
          mapper_d     = mapper_flags[7:0];
          mirror_d     = mapper_flags[14];
          fourScreen_d = mapper_flags[16];
          battery_d    = mapper_flags[25];
          done_d       = 1'b0;
          error_d      = 1'b0;
          if (prg_pages == 8'd0) begin
            error_d = 1'b1;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            busy_d  = 1'b1;
            ctr_d   = 4'd0;
            state_d = S_HEADER;
          end
        end
      end
      S_HEADER: begin
        if (out_ready) begin
          ctr_d = ctr_q + 4'd1;
          if (ctr_q == 4'd15) begin
            memAddr_d   = PRG_BASE;
            bytesLeft_d = {3'b000, prgPages_q, 14'd0};
            regionChr_d = 1'b0;
            state_d     = S_REQ;
          end
        end
      end
      S_REQ: begin
        memRd_d = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_ack) begin
          memRd_d    = 1'b0;
          outData_d  = mem_data;
          outValid_d = 1'b1;
          state_d    = S_OUT;
        end
      end
      S_OUT: begin
        // Last byte of PRG rolls over into the CHR region when the cart has CHR ROM
        if (out_ready) begin
          outValid_d  = 1'b0;
          memAddr_d   = memAddr_q + 25'd1;
          bytesLeft_d = bytesLeft_q - 25'd1;
          if (bytesLeft_q != 25'd1) begin
            state_d = S_REQ;
          end else if (!regionChr_q && chrPages_q != 8'd0) begin
            regionChr_d = 1'b1;
            memAddr_d   = CHR_BASE;
            bytesLeft_d = {4'b0000, chrPages_q, 13'd0};
            state_d     = S_REQ;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_addr  = memAddr_q;
  assign mem_rd    = memRd_q;
  assign out_valid = outValid_q | (state_q == S_HEADER);
  assign out_data  = (state_q == S_HEADER) ? hdrByte : outData_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule
